// File: rtl/dmem_sized.sv
// Byte-addressed 32-bit data memory with sized, aligned accesses.
// Zero-fills itself after reset and answers every request one cycle later.
module dmem_sized #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW+1:0] req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          busy
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    localparam int unsigned DEPTH_U = DEPTH;
    localparam int unsigned LAST_U  = DEPTH_U - 1;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [31:0]   mem [DEPTH];
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          accept;
    logic          illegal;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;
    logic [3:0]    st_be;
    logic [31:0]   st_data;

    assign word_idx  = req_addr[AW+1:2];
    assign lane      = req_addr[1:0];
    assign req_ready = (state_q == S_IDLE) && !reset;
    assign busy      = (state_q == S_CLEAR) || reset;
    assign accept    = req_valid && req_ready;
    assign rd_word   = mem[word_idx];

    // Response is masked while reset is held so a pending pulse never escapes.
    assign rsp_valid = rsp_valid_q && !reset;
    assign rsp_rdata = reset ? 32'h0 : rsp_rdata_q;
    assign rsp_err   = rsp_err_q && !reset;

    always_comb begin
        illegal = (32'(word_idx) >= DEPTH_U);
        unique case (req_size)
            2'b00:   illegal = illegal;
            2'b01:   illegal = illegal || lane[0];
            2'b10:   illegal = illegal || (lane != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = rd_word;
        unique case (req_size)
            2'b00:   ld_data = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~req_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        st_be   = 4'b1111;
        st_data = req_wdata;
        unique case (req_size)
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        mem_be      = 4'b0000;
        mem_addr    = word_idx;
        mem_wdata   = st_data;
        if (reset) begin
            state_d     = S_CLEAR;
            ptr_d       = '0;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_be    = 4'b1111;
                    mem_addr  = ptr_q;
                    mem_wdata = 32'h0;
                    ptr_d     = ptr_q + AW'(1);
                    if (32'(ptr_q) == LAST_U) begin
                        state_d = S_IDLE;
                        ptr_d   = '0;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = illegal;
                        rsp_rdata_d = (illegal || req_we) ? 32'h0 : ld_data;
                        if (req_we && !illegal) begin
                            mem_we = 1'b1;
                            mem_be = st_be;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        ptr_q       <= ptr_d;
        rsp_valid_q <= rsp_valid_d;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= rsp_err_d;
    end

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: clear timing, sized loads/stores,
// illegal requests, back-to-back traffic and reset corner cases.
module tb_dmem_sized;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [8:0]  req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [8:0]  b_req_addr;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    int errors = 0;
    int checks = 0;

    dmem_sized u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    dmem_sized #(.DEPTH(100)) u_dut100 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (b_req_valid),
        .req_ready    (b_req_ready),
        .req_we       (b_req_we),
        .req_addr     (b_req_addr),
        .req_size     (b_req_size),
        .req_unsigned (b_req_unsigned),
        .req_wdata    (b_req_wdata),
        .rsp_valid    (b_rsp_valid),
        .rsp_rdata    (b_rsp_rdata),
        .rsp_err      (b_rsp_err),
        .busy         (b_busy)
    );

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_a(input string tag, input vec_t v);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_addr     = v.addr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_wdata    = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rdata"}, rsp_rdata, v.rdata);
        chk({tag, " err"}, 32'(rsp_err), 32'(v.err));
        @(negedge clk);
        chk({tag, " pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, " hold"}, {rsp_rdata[31:1], rsp_err},
            {v.rdata[31:1], v.err});
    endtask

    task automatic run_b(input string tag, input vec_t v);
        b_req_valid    = 1'b1;
        b_req_we       = v.we;
        b_req_addr     = v.addr;
        b_req_size     = v.size;
        b_req_unsigned = v.uns;
        b_req_wdata    = v.wdata;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        chk({tag, " valid"}, 32'(b_rsp_valid), 32'd1);
        chk({tag, " rdata"}, b_rsp_rdata, v.rdata);
        chk({tag, " err"}, 32'(b_rsp_err), 32'(v.err));
    endtask

    // Called at the negedge where reset is released.
    task automatic count_clear(input string tag);
        int first_a = -1;
        int first_b = -1;
        int bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy && first_a < 0) first_a = i;
            if (!b_busy && first_b < 0) first_b = i;
            if (req_ready == busy) bad++;
            @(negedge clk);
        end
        chk({tag, " clear128"}, first_a, 128);
        chk({tag, " clear100"}, first_b, 100);
        chk({tag, " ready_vs_busy"}, bad, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 9'h014, 2'b10, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 9'h1FC, 2'b10, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
        tbl[2]  = '{1'b1, 9'h010, 2'b10, 1'b0, 32'h11223344, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b0, 9'h013, 2'b00, 1'b0, 32'h0,        32'h0000_0011, 1'b0};
        tbl[4]  = '{1'b1, 9'h011, 2'b00, 1'b0, 32'h0000_00F0, 32'h0000_0000, 1'b0};
        tbl[5]  = '{1'b0, 9'h010, 2'b01, 1'b0, 32'h0,        32'hFFFF_F044, 1'b0};
        tbl[6]  = '{1'b0, 9'h010, 2'b01, 1'b1, 32'h0,        32'h0000_F044, 1'b0};
        tbl[7]  = '{1'b1, 9'h004, 2'b10, 1'b0, 32'hA5A55A5A, 32'h0000_0000, 1'b0};
        tbl[8]  = '{1'b0, 9'h002, 2'b10, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        tbl[9]  = '{1'b1, 9'h005, 2'b01, 1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
        tbl[10] = '{1'b0, 9'h004, 2'b11, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        tbl[11] = '{1'b1, 9'h004, 2'b11, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        tbl[12] = '{1'b0, 9'h004, 2'b10, 1'b0, 32'h0,        32'hA5A5_5A5A, 1'b0};
        tbl[13] = '{1'b0, 9'h012, 2'b00, 1'b1, 32'h0,        32'h0000_0022, 1'b0};
        tbl[14] = '{1'b0, 9'h011, 2'b00, 1'b0, 32'h0,        32'hFFFF_FFF0, 1'b0};
        tbl[15] = '{1'b0, 9'h012, 2'b01, 1'b1, 32'h0,        32'h0000_1122, 1'b0};
        tbl[16] = '{1'b1, 9'h012, 2'b01, 1'b0, 32'h0000_8001, 32'h0000_0000, 1'b0};
        tbl[17] = '{1'b0, 9'h012, 2'b01, 1'b0, 32'h0,        32'hFFFF_8001, 1'b0};
        tbl[18] = '{1'b0, 9'h010, 2'b10, 1'b0, 32'h0,        32'h8001_F044, 1'b0};
        tbl[19] = '{1'b0, 9'h013, 2'b00, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0};

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
        b_req_size = 2'b10; b_req_unsigned = 1'b0; b_req_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst req_ready", 32'(req_ready), 32'd0);

        reset = 1'b0;
        count_clear("init");

        for (int i = 0; i < 20; i++) begin
            run_a($sformatf("vec%0d", i), tbl[i]);
        end

        // Store then load the same word on consecutive cycles.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0; req_wdata = 32'h0;
        chk("b2b st valid", 32'(rsp_valid), 32'd1);
        chk("b2b st err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b ld valid", 32'(rsp_valid), 32'd1);
        chk("b2b ld rdata", rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("b2b idle", 32'(rsp_valid), 32'd0);

        run_b("d100 st396", '{1'b1, 9'd396, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0});
        run_b("d100 ld396", '{1'b0, 9'd396, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0});
        run_b("d100 ld400", '{1'b0, 9'd400, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1});
        run_b("d100 st400", '{1'b1, 9'd400, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1});
        run_b("d100 ld396b", '{1'b0, 9'd396, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0});

        // Reset lands the cycle after a load is accepted.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h020; req_size = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstpend valid", 32'(rsp_valid), 32'd0);
        chk("rstpend rdata", rsp_rdata, 32'h0);
        chk("rstpend busy", 32'(busy), 32'd1);
        chk("rstpend ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rstpend valid2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        repeat (40) @(negedge clk);
        chk("midclr busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midclr rst busy", 32'(busy), 32'd1);
        chk("midclr rst ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        count_clear("reclr");

        run_a("post 0x020", '{1'b0, 9'h020, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0});
        run_a("post 0x010", '{1'b0, 9'h010, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0});
        run_a("post 0x004", '{1'b0, 9'h004, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0});
        run_b("d100 post396", '{1'b0, 9'd396, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
